clause_bin_reader: RTL and testbench

Sequential read-back engine for the clause array: on a start pulse it walks every clause row of the current bin and streams each row (per-variable literal codes, clause length, row index) out on a valid/ready interface to the bin store. It is the reader counterpart of the row-by-row one-hot write path into `clause_array`. It sits between `clause_array` and the bin write-back/memory side.

---
 rtl/clause_bin_reader.sv | 153 +++++++++++++++
 tb/tb_clause_bin_reader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clause_bin_reader.sv
// Read-back engine: walks every clause row of the current bin and streams it out over valid/ready.
// Optional feature macro: CLAUSE_BIN_READER_SKIP_EMPTY_EN (drop rows whose length is zero).
module clause_bin_reader #(
   parameter int NUM_CLAUSES_A_BIN = 8,
   parameter int NUM_VARS_A_BIN    = 8,
   parameter int WIDTH_C_LEN       = 5,
   parameter int WIDTH_IDX         = $clog2(NUM_CLAUSES_A_BIN)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start_i,
   output logic [NUM_CLAUSES_A_BIN-1:0]  rd_o,
   input  logic [NUM_VARS_A_BIN*3-1:0]   clause_i,
   input  logic [WIDTH_C_LEN-1:0]        clause_len_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [NUM_VARS_A_BIN*3-1:0]   out_clause_o,
   output logic [WIDTH_C_LEN-1:0]        out_len_o,
   output logic [WIDTH_IDX-1:0]          out_index_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic [WIDTH_IDX:0]            clause_count_o
);

   localparam int CNT_W = WIDTH_IDX + 1;
   localparam logic [WIDTH_IDX-1:0]         ROW_LAST = WIDTH_IDX'(NUM_CLAUSES_A_BIN - 1);
   localparam logic [WIDTH_IDX-1:0]         ROW_ONE  = WIDTH_IDX'(1);
   localparam logic [CNT_W-1:0]             CNT_ONE  = CNT_W'(1);
   localparam logic [NUM_CLAUSES_A_BIN-1:0] SEL_ROW0 = {{(NUM_CLAUSES_A_BIN-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_READ = 3'd1,
      ST_CAPT = 3'd2,
      ST_SEND = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t                         state_r;
   state_t                         state_s;
   logic [WIDTH_IDX-1:0]           row_r;
   logic [WIDTH_IDX-1:0]           row_s;
   logic [CNT_W-1:0]               count_r;
   logic [CNT_W-1:0]               count_s;
   logic [NUM_CLAUSES_A_BIN-1:0]   rd_r;
   logic                           out_valid_r;
   logic [NUM_VARS_A_BIN*3-1:0]    out_clause_r;
   logic [WIDTH_C_LEN-1:0]         out_len_r;
   logic [WIDTH_IDX-1:0]           out_index_r;
   logic                           busy_r;
   logic                           done_r;

   // Next-state, next-row and emitted-row count decode
   always_comb begin
      state_s = state_r;
      row_s   = row_r;
      count_s = count_r;
      case (state_r)
         ST_IDLE: begin
            if (start_i) begin
               state_s = ST_READ;
               row_s   = {WIDTH_IDX{1'b0}};
               count_s = {CNT_W{1'b0}};
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_READ: begin
            state_s = ST_CAPT;
         end
         ST_CAPT: begin
`ifdef CLAUSE_BIN_READER_SKIP_EMPTY_EN
            // An empty row is captured but never offered to the sink
            if (clause_len_i == {WIDTH_C_LEN{1'b0}}) begin
               if (row_r == ROW_LAST) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_READ;
                  row_s   = row_r + ROW_ONE;
               end
            end else begin
               state_s = ST_SEND;
            end
`else
            state_s = ST_SEND;
`endif
         end
         ST_SEND: begin
            if (out_ready_i) begin
               count_s = count_r + CNT_ONE;
               if (row_r == ROW_LAST) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_READ;
                  row_s   = row_r + ROW_ONE;
               end
            end else begin
               state_s = ST_SEND;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, counters and next-state-decoded registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         row_r       <= {WIDTH_IDX{1'b0}};
         count_r     <= {CNT_W{1'b0}};
         rd_r        <= {NUM_CLAUSES_A_BIN{1'b0}};
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         row_r       <= row_s;
         count_r     <= count_s;
         rd_r        <= (state_s == ST_READ) ? (SEL_ROW0 << row_s) : {NUM_CLAUSES_A_BIN{1'b0}};
         out_valid_r <= (state_s == ST_SEND);
         busy_r      <= (state_s != ST_IDLE);
         done_r      <= (state_s == ST_DONE);
      end
   end

   // Capture the row answered by clause_array one cycle after its read select
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_clause_r <= {(NUM_VARS_A_BIN*3){1'b0}};
         out_len_r    <= {WIDTH_C_LEN{1'b0}};
         out_index_r  <= {WIDTH_IDX{1'b0}};
      end else if (state_r == ST_CAPT) begin
         out_clause_r <= clause_i;
         out_len_r    <= clause_len_i;
         out_index_r  <= row_r;
      end
   end

   assign rd_o           = rd_r;
   assign out_valid_o    = out_valid_r;
   assign out_clause_o   = out_clause_r;
   assign out_len_o      = out_len_r;
   assign out_index_o    = out_index_r;
   assign busy_o         = busy_r;
   assign done_o         = done_r;
   assign clause_count_o = count_r;

endmodule

// File: tb/tb_clause_bin_reader.sv
// Self-checking bench for clause_bin_reader: bin-level row model, scoreboard compare on every
// cycle, plus literal pins for row 0, dump latency and final count.
module tb_clause_bin_reader;

   localparam int N = 8;
`ifdef CLAUSE_BIN_READER_SKIP_EMPTY_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   typedef struct packed {
      logic [23:0] c;
      logic [4:0]  l;
      logic [2:0]  i;
   } row_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [7:0]  rd_o;
   logic [23:0] clause_i = 24'hFFFFFF;
   logic [4:0]  clause_len_i = 5'h1F;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [23:0] out_clause_o;
   logic [4:0]  out_len_o;
   logic [2:0]  out_index_o;
   logic        busy_o;
   logic        done_o;
   logic [3:0]  clause_count_o;

   clause_bin_reader dut (
      .clk(clk), .rst(rst), .start_i(start_i), .rd_o(rd_o),
      .clause_i(clause_i), .clause_len_i(clause_len_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_clause_o(out_clause_o), .out_len_o(out_len_o), .out_index_o(out_index_o),
      .busy_o(busy_o), .done_o(done_o), .clause_count_o(clause_count_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // clause_array stand-in: answers the selected row one cycle after rd_o, poison otherwise
   logic [23:0] bin_c [N];
   logic [4:0]  bin_l [N];
   always @(posedge clk) begin
      if (rd_o != 8'h00) begin
         clause_i     <= bin_c[$clog2(rd_o)];
         clause_len_i <= bin_l[$clog2(rd_o)];
      end else begin
         clause_i     <= 24'hFFFFFF;
         clause_len_i <= 5'h1F;
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   row_t exp_q[$];
   int   t0, exp_done_off, exp_count, exp_rd, hs_cnt, done_cnt;
   int   last_done_off, last_hs_idx;
   bit   done_seen;
   row_t first_hs;
   bit   pend_prev = 1'b0;
   bit   hs_prev = 1'b0;
   int   hs_prev_row = 0;
   row_t held;

   // Compare process: every cycle, away from the active edge
   always @(negedge clk) begin
      row_t cur;
      row_t r;
      cur = {out_clause_o, out_len_o, out_index_o};
      if (rst) begin
         pend_prev = 1'b0;
         hs_prev   = 1'b0;
      end else begin
         if (pend_prev) begin
            chk("valid_hold", {31'd0, out_valid_o}, 32'd1);
            chk("data_hold", cur, held);
         end
         if (hs_prev && hs_prev_row < N - 1)
            chk("rd_after_hs", {24'd0, rd_o}, 32'd1 << (hs_prev_row + 1));
         if (rd_o != 8'h00) begin
            chk("rd_order", {24'd0, rd_o}, 32'd1 << exp_rd);
            chk("rd_no_valid", {31'd0, out_valid_o}, 32'd0);
            exp_rd++;
         end
         if (rd_o != 8'h00 || out_valid_o || done_o)
            chk("busy_active", {31'd0, busy_o}, 32'd1);
         hs_prev = out_valid_o && out_ready_i;
         if (hs_prev) begin
            hs_prev_row = int'(out_index_o);
            last_hs_idx = int'(out_index_o);
            if (hs_cnt == 0) first_hs = cur;
            if (exp_q.size() == 0) begin
               chk("hs_unexpected", cur, 32'd0);
            end else begin
               r = exp_q.pop_front();
               chk("hs_row", cur, r);
            end
            chk("hs_count", {28'd0, clause_count_o}, hs_cnt);
            hs_cnt++;
         end
         pend_prev = out_valid_o && !out_ready_i;
         held      = cur;
         if (done_o) begin
            last_done_off = cyc - t0 + 1;
            chk("done_time", last_done_off, exp_done_off);
            chk("done_count", {28'd0, clause_count_o}, exp_count);
            chk("done_q_empty", exp_q.size(), 32'd0);
            done_cnt++;
            done_seen = 1'b1;
         end
      end
   end

   task automatic load_bin(input bit only_last);
      for (int i = 0; i < N; i++) begin
         bin_c[i] = 24'h000000;
         bin_l[i] = 5'd0;
      end
      if (only_last) begin
         bin_c[7] = 24'h600000;
         bin_l[7] = 5'd1;
      end else begin
         bin_c[0] = 24'h000042; bin_l[0] = 5'd2;
         bin_c[1] = 24'h0A0C01; bin_l[1] = 5'd3;
         bin_c[2] = 24'h400008; bin_l[2] = 5'd2;
         bin_c[3] = 24'h0001FF; bin_l[3] = 5'd3;
         bin_c[4] = 24'h924924; bin_l[4] = 5'd8;
      end
   endtask

   // One dump: build expectations from the bin, start, steer ready/start/reset, wait for done
   task automatic run_dump(input int stall_row, input int stall_len, input int again_row,
                           input int abort_row);
      int  stalls;
      bit  aborted;
      bit  again_done;
      exp_q.delete();
      exp_done_off = 1;
      exp_count    = 0;
      for (int i = 0; i < N; i++) begin
         if (!SKIP || bin_l[i] != 5'd0) begin
            exp_q.push_back({bin_c[i], bin_l[i], 3'(i)});
            exp_count++;
            exp_done_off += 3;
            if (i == stall_row) exp_done_off += stall_len;
         end else begin
            exp_done_off += 2;
         end
      end
      exp_rd = 0; hs_cnt = 0; done_cnt = 0; done_seen = 1'b0;
      stalls = 0; aborted = 1'b0; again_done = 1'b0;
      @(posedge clk); #2;
      start_i = 1'b1;
      t0 = cyc + 1;
      @(posedge clk); #2;
      start_i = 1'b0;
      for (int c = 0; c < 300 && !done_seen && !aborted; c++) begin
         if (abort_row >= 0 && out_valid_o && int'(out_index_o) == abort_row) begin
            #1 rst = 1'b1;
            #1;
            chk("abort_rd", {24'd0, rd_o}, 32'd0);
            chk("abort_valid", {31'd0, out_valid_o}, 32'd0);
            chk("abort_data", {out_clause_o, out_len_o, out_index_o}, 32'd0);
            chk("abort_busy_done", {30'd0, busy_o, done_o}, 32'd0);
            chk("abort_count", {28'd0, clause_count_o}, 32'd0);
            aborted = 1'b1;
         end else begin
            if (again_row >= 0 && !again_done && out_valid_o && int'(out_index_o) == again_row) begin
               start_i    = 1'b1;
               again_done = 1'b1;
            end else begin
               start_i = 1'b0;
            end
            if (stall_row >= 0 && out_valid_o && int'(out_index_o) == stall_row && stalls < stall_len) begin
               out_ready_i = 1'b0;
               stalls++;
            end else begin
               out_ready_i = 1'b1;
            end
            @(posedge clk); #2;
         end
      end
      start_i     = 1'b0;
      out_ready_i = 1'b1;
      if (aborted) begin
         repeat (2) @(posedge clk);
         #2 rst = 1'b0;
         exp_q.delete();
         repeat (4) @(posedge clk);
         #2;
         chk("abort_no_done", done_cnt, 32'd0);
         chk("abort_idle", {31'd0, busy_o}, 32'd0);
      end else if (!done_seen) begin
         n_checks++;
         n_errors++;
         $display("FAIL dump_timeout actual=no_done required=done_o within 300 cycles");
      end else begin
         repeat (3) @(posedge clk);
         #2;
         chk("post_busy", {31'd0, busy_o}, 32'd0);
         chk("post_single_done", done_cnt, 32'd1);
         chk("post_count_hold", {28'd0, clause_count_o}, exp_count);
      end
   endtask

   initial begin
      rst = 1'b1; start_i = 1'b0; out_ready_i = 1'b1;
      load_bin(1'b0);
      #3;
      chk("rst_rd", {24'd0, rd_o}, 32'd0);
      chk("rst_outs", {out_clause_o, out_len_o, out_index_o}, 32'd0);
      chk("rst_flags", {29'd0, out_valid_o, busy_o, done_o}, 32'd0);
      chk("rst_count", {28'd0, clause_count_o}, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      // Full dump, ready tied high
      run_dump(-1, 0, -1, -1);
      chk("lit_row0", first_hs, {24'h000042, 5'd2, 3'd0});
      chk("lit_done_T", last_done_off, SKIP ? 32'd22 : 32'd25);
      chk("lit_count", {28'd0, clause_count_o}, SKIP ? 32'd5 : 32'd8);

      // Backpressure on row 3 for 5 cycles
      run_dump(3, 5, -1, -1);
      chk("lit_stall_done_T", last_done_off, SKIP ? 32'd27 : 32'd30);

      // Start pulsed while busy at row 2
      run_dump(-1, 0, 2, -1);

      // Only the last row non-empty
      load_bin(1'b1);
      run_dump(-1, 0, -1, -1);
      chk("lit_last_idx", last_hs_idx, 32'd7);
      chk("lit_last_count", {28'd0, clause_count_o}, SKIP ? 32'd1 : 32'd8);
      chk("lit_last_done_T", last_done_off, SKIP ? 32'd18 : 32'd25);

      // Reset during SEND of row 1, then a clean dump from row 0
      load_bin(1'b0);
      run_dump(-1, 0, -1, 1);
      run_dump(-1, 0, -1, -1);
      chk("lit_after_rst_row0", first_hs, {24'h000042, 5'd2, 3'd0});

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
